// File: rtl/find_stars_pkg.sv
// find_stars_pkg: screen geometry defaults, coordinate widths and shared types for the plot scheduler
package find_stars_pkg;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 3;
  typedef enum logic {IDLE, CLEAR} state_t;
  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;
endpackage

// File: rtl/plot_rr_arb.sv
// plot_rr_arb: combinational 2-way round-robin grant that favours the requester named by rr_ptr
module plot_rr_arb (
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       rr_ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant[0] = enable && valid[0] && (!rr_ptr || !valid[1]);
    grant[1] = enable && valid[1] && (rr_ptr || !valid[0]);
  end
endmodule

// File: rtl/vga_plot_scheduler.sv
// vga_plot_scheduler: round-robin pixel-port sharing with a full-screen clear; VGA_PLOT_SCHEDULER_CLIP_EN drops off-screen pixels and counts them in clip_count
module vga_plot_scheduler
  import find_stars_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int COLOUR_W = find_stars_pkg::COLOUR_W,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*X_W-1:0]      req_x,
  input  logic [2*Y_W-1:0]      req_y,
  input  logic [2*COLOUR_W-1:0] req_colour,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic                  clear_done,
  output logic [X_W-1:0]        x,
  output logic [Y_W-1:0]        y,
  output logic [COLOUR_W-1:0]   colour,
  output logic                  plot
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
  ,
  output logic [15:0]           clip_count
`endif
);
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
  state_t state, state_nxt;
  logic en, rr_ptr, sel, wrap, last;
  logic [1:0] grant;
  logic [X_W-1:0] cx, nx, rx;
  logic [Y_W-1:0] cy, ny, ry;
  logic [COLOUR_W-1:0] rc;
  assign en = state == IDLE && !clear_done && !clear_start && !reset;
  assign req_ready = grant;
  plot_rr_arb u_arb (.valid(req_valid), .enable(en), .rr_ptr, .grant);
  always_comb begin
    sel = grant[1];
    rx = sel ? req_x[2*X_W-1:X_W] : req_x[X_W-1:0];
    ry = sel ? req_y[2*Y_W-1:Y_W] : req_y[Y_W-1:0];
    rc = sel ? req_colour[2*COLOUR_W-1:COLOUR_W] : req_colour[COLOUR_W-1:0];
    wrap = cx == X_LAST;
    nx = wrap ? '0 : cx + 1'b1;
    ny = wrap ? cy + 1'b1 : cy;
    last = nx == X_LAST && ny == Y_LAST;
    state_nxt = state == IDLE ? (clear_start ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  end
  always_ff @(posedge clock) state <= reset ? IDLE : state_nxt;
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
  logic in_range;
  assign in_range = rx <= X_LAST && ry <= Y_LAST;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= 1'b0;
      cx <= '0;
      cy <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      plot <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
      clip_count <= '0;
`endif
    end else begin
      plot <= 1'b0;
      clear_done <= 1'b0;
      if (state == CLEAR) begin
        cx <= nx;
        cy <= ny;
        x <= nx;
        y <= ny;
        colour <= BG_COLOUR;
        plot <= 1'b1;
        clear_busy <= !last;
        clear_done <= last;
      end else if (clear_start) begin
        cx <= '0;
        cy <= '0;
        x <= '0;
        y <= '0;
        colour <= BG_COLOUR;
        plot <= 1'b1;
        clear_busy <= 1'b1;
      end else if (|grant) begin
        rr_ptr <= ~sel;
        x <= rx;
        y <= ry;
        colour <= rc;
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
        plot <= in_range;
        if (!in_range && clip_count != 16'hffff) clip_count <= clip_count + 1'b1;
`else
        plot <= 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_vga_plot_scheduler.sv
// tb_vga_plot_scheduler: randomized and directed checks of arbitration, clear sweep, collisions, reset abort and clipping
module tb_vga_plot_scheduler;
  localparam int W = 160;
  localparam int H = 120;
  localparam int N = W * H;
  logic clock = 1'b0;
  logic reset;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [15:0] req_x;
  logic [13:0] req_y;
  logic [5:0] req_colour;
  logic clear_start, clear_busy, clear_done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic plot;
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
  logic [15:0] clip_count;
`endif
  int errors = 0;
  int checks = 0;
  logic m_ptr;
  logic [7:0] m_x;
  logic [6:0] m_y;
  logic [2:0] m_c;
  always #5 clock = ~clock;
  vga_plot_scheduler dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done), .x(x), .y(y), .colour(colour), .plot(plot)
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
    , .clip_count(clip_count)
`endif
  );
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    clear_start = 1'b0;
    req_valid = 2'b11;
    req_x = {8'd7, 8'd9};
    req_y = {7'd3, 7'd4};
    req_colour = {3'd1, 3'd2};
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
    tick();
    tick();
    checks++;
    if ({x, y, colour, plot, clear_busy, clear_done} !== '0)
      begin errors++; $display("FAIL reset_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b want all 0", x, y, colour, plot, clear_busy, clear_done); end
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
    checks++;
    if (clip_count !== 16'd0) begin errors++; $display("FAIL reset_clip: got %0d want 0", clip_count); end
`endif
    reset = 1'b0;
    req_valid = 2'b00;
    m_ptr = 1'b0;
  endtask
  task automatic test_contention();
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;
    for (int i = 0; i < 4; i++) begin
      x0 = 8'($urandom_range(0, W - 1)); x1 = 8'($urandom_range(0, W - 1));
      y0 = 7'($urandom_range(0, H - 1)); y1 = 7'($urandom_range(0, H - 1));
      c0 = 3'($urandom); c1 = 3'($urandom);
      req_valid = 2'b11;
      req_x = {x1, x0}; req_y = {y1, y0}; req_colour = {c1, c0};
      #1;
      checks++;
      if (req_ready !== exp_g[i]) begin errors++; $display("FAIL contention_grant%0d: got %b want %b", i, req_ready, exp_g[i]); end
      m_x = exp_g[i][1] ? x1 : x0; m_y = exp_g[i][1] ? y1 : y0; m_c = exp_g[i][1] ? c1 : c0;
      m_ptr = !exp_g[i][1];
      tick();
      checks++;
      if ({plot, x, y, colour} !== {1'b1, m_x, m_y, m_c})
        begin errors++; $display("FAIL contention_pixel%0d: got plot=%b (%0d,%0d,%0d) want plot=1 (%0d,%0d,%0d)", i, plot, x, y, colour, m_x, m_y, m_c); end
    end
    req_valid = 2'b00;
    tick();
    checks++;
    if (plot !== 1'b0) begin errors++; $display("FAIL contention_idle: got plot=%b want 0", plot); end
  endtask
  task automatic test_single();
    req_valid = 2'b01;
    req_x = {8'd0, 8'd10}; req_y = {7'd0, 7'd20}; req_colour = {3'd0, 3'b101};
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if ({plot, x, y, colour} !== {1'b1, 8'd10, 7'd20, 3'b101})
      begin errors++; $display("FAIL single_pixel: got plot=%b (%0d,%0d,%0d) want plot=1 (10,20,5)", plot, x, y, colour); end
    tick();
    checks++;
    if ({plot, x, y, colour} !== {1'b0, 8'd10, 7'd20, 3'b101})
      begin errors++; $display("FAIL single_after: got plot=%b (%0d,%0d,%0d) want plot=0 (10,20,5)", plot, x, y, colour); end
    m_ptr = 1'b1;
    m_x = 8'd10; m_y = 7'd20; m_c = 3'b101;
  endtask
  task automatic test_random();
    logic [1:0] v, exp_r;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] c0, c1;
    int g;
    for (int i = 0; i < 200; i++) begin
      v = 2'($urandom_range(0, 3));
      x0 = 8'($urandom_range(0, W - 1)); x1 = 8'($urandom_range(0, W - 1));
      y0 = 7'($urandom_range(0, H - 1)); y1 = 7'($urandom_range(0, H - 1));
      c0 = 3'($urandom); c1 = 3'($urandom);
      req_valid = v; req_x = {x1, x0}; req_y = {y1, y0}; req_colour = {c1, c0};
      g = -1;
      if (v != 2'b00) g = v[m_ptr] ? int'(m_ptr) : int'(!m_ptr);
      exp_r = g < 0 ? 2'b00 : (g == 1 ? 2'b10 : 2'b01);
      #1;
      checks++;
      if (req_ready !== exp_r) begin errors++; $display("FAIL random_ready%0d: got %b want %b (valid %b)", i, req_ready, exp_r, v); end
      if (g >= 0) begin
        m_x = g == 1 ? x1 : x0; m_y = g == 1 ? y1 : y0; m_c = g == 1 ? c1 : c0;
        m_ptr = g == 0;
      end
      tick();
      checks++;
      if ({plot, x, y, colour} !== {g >= 0, m_x, m_y, m_c})
        begin errors++; $display("FAIL random_pixel%0d: got plot=%b (%0d,%0d,%0d) want plot=%b (%0d,%0d,%0d)", i, plot, x, y, colour, g >= 0, m_x, m_y, m_c); end
    end
    req_valid = 2'b00;
  endtask
  task automatic test_clear();
    int bad = 0, plots = 0, dones = 0;
    req_valid = 2'b00;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (plot === 1'b1) plots++;
      if (clear_done === 1'b1) dones++;
      if (plot !== 1'b1 || x !== 8'(k % W) || y !== 7'(k / W) || colour !== 3'b000 ||
          clear_busy !== (k != N - 1) || clear_done !== (k == N - 1) || req_ready !== 2'b00) bad++;
      if (k == 0) begin
        checks++;
        if ({plot, x, y, clear_busy} !== {1'b1, 8'd0, 7'd0, 1'b1}) begin errors++; $display("FAIL clear_first: got plot=%b (%0d,%0d) busy=%b want plot=1 (0,0) busy=1", plot, x, y, clear_busy); end
      end
      if (k == W) begin
        checks++;
        if ({x, y} !== {8'd0, 7'd1}) begin errors++; $display("FAIL clear_row1: got (%0d,%0d) want (0,1)", x, y); end
      end
      if (k == N - 1) begin
        checks++;
        if ({plot, x, y, clear_done, clear_busy} !== {1'b1, 8'd159, 7'd119, 1'b1, 1'b0})
          begin errors++; $display("FAIL clear_last: got plot=%b (%0d,%0d) done=%b busy=%b want plot=1 (159,119) done=1 busy=0", plot, x, y, clear_done, clear_busy); end
      end
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL clear_sweep: got %0d bad cycles want 0", bad); end
    checks++;
    if (plots != N) begin errors++; $display("FAIL clear_plots: got %0d want %0d", plots, N); end
    checks++;
    if (dones != 1) begin errors++; $display("FAIL clear_dones: got %0d want 1", dones); end
    checks++;
    if ({plot, clear_done, clear_busy} !== 3'b000) begin errors++; $display("FAIL clear_after: got plot=%b done=%b busy=%b want 000", plot, clear_done, clear_busy); end
    m_x = 8'd159; m_y = 7'd119; m_c = 3'b000;
  endtask
  task automatic test_collision();
    int bad = 0;
    req_valid = 2'b01;
    req_x = {8'd0, 8'd33}; req_y = {7'd0, 7'd44}; req_colour = {3'd0, 3'd6};
    clear_start = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL collision_ready: got %b want 00", req_ready); end
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (req_ready !== 2'b00 || colour !== 3'b000 || plot !== 1'b1 || clear_done !== (k == N - 1)) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL collision_wait: got %0d bad cycles want 0", bad); end
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL collision_accept: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if ({plot, x, y, colour} !== {1'b1, 8'd33, 7'd44, 3'd6})
      begin errors++; $display("FAIL collision_pixel: got plot=%b (%0d,%0d,%0d) want plot=1 (33,44,6)", plot, x, y, colour); end
    m_ptr = 1'b1;
  endtask
  task automatic test_reset_mid_clear();
    int plots = 0, dones = 0;
    req_valid = 2'b00;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 500; k++) tick();
    checks++;
    if ({plot, x, y, clear_busy} !== {1'b1, 8'd20, 7'd3, 1'b1})
      begin errors++; $display("FAIL abort_pixel500: got plot=%b (%0d,%0d) busy=%b want plot=1 (20,3) busy=1", plot, x, y, clear_busy); end
    reset = 1'b1;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin errors++; $display("FAIL abort_ready: got %b want 00", req_ready); end
    tick();
    reset = 1'b0;
    req_valid = 2'b00;
    checks++;
    if ({x, y, colour, plot, clear_busy, clear_done, req_ready} !== '0)
      begin errors++; $display("FAIL abort_outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b done=%b ready=%b want all 0", x, y, colour, plot, clear_busy, clear_done, req_ready); end
    m_ptr = 1'b0;
    for (int k = 0; k < N + 100; k++) begin
      if (plot === 1'b1) plots++;
      if (clear_done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
    checks++;
    if (plots != 0) begin errors++; $display("FAIL abort_plots: got %0d want 0", plots); end
  endtask
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
  task automatic test_clip();
    req_valid = 2'b01;
    req_x = {8'd0, 8'd160}; req_y = {7'd0, 7'd5}; req_colour = {3'd0, 3'd7};
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL clip_ready: got %b want 01", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if (plot !== 1'b0) begin errors++; $display("FAIL clip_plot: got %b want 0", plot); end
    checks++;
    if (clip_count !== 16'd1) begin errors++; $display("FAIL clip_count1: got %0d want 1", clip_count); end
    req_valid = 2'b10;
    req_x = {8'd159, 8'd0}; req_y = {7'd119, 7'd0}; req_colour = {3'b011, 3'd0};
    #1;
    checks++;
    if (req_ready !== 2'b10) begin errors++; $display("FAIL edge_ready: got %b want 10", req_ready); end
    tick();
    req_valid = 2'b00;
    checks++;
    if ({plot, x, y, colour} !== {1'b1, 8'd159, 7'd119, 3'b011})
      begin errors++; $display("FAIL edge_pixel: got plot=%b (%0d,%0d,%0d) want plot=1 (159,119,3)", plot, x, y, colour); end
    checks++;
    if (clip_count !== 16'd1) begin errors++; $display("FAIL clip_count2: got %0d want 1", clip_count); end
  endtask
`endif
  initial begin
    test_reset();
    test_contention();
    test_single();
    test_random();
    test_clear();
    test_collision();
    test_reset_mid_clear();
`ifdef VGA_PLOT_SCHEDULER_CLIP_EN
    test_clip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
